// File: rtl/bsg_wormhole_concentrator_arbiter.sv
// Concentrates num_in_p wormhole links onto one link. Round-robin arbitration works per packet,
// and each input is buffered by a 2-entry FIFO. Flits are passed through unmodified.
module bsg_wormhole_concentrator_arbiter #(
    parameter int unsigned flit_width_p = 16,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned cid_width_p  = 2,
    parameter int unsigned cord_width_p = 4,
    parameter int unsigned num_in_p     = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p-1:0]              links_v_i,
    input  logic [num_in_p*flit_width_p-1:0] links_data_i,
    output logic [num_in_p-1:0]              links_ready_and_rev_o,
    output logic                             concentrated_link_v_o,
    output logic [flit_width_p-1:0]          concentrated_link_data_o,
    input  logic                             concentrated_link_ready_and_rev_i
);

    localparam int unsigned SelW = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    if (flit_width_p < cord_width_p + len_width_p + cid_width_p) begin : g_bad_width
        $error("flit_width_p is too narrow for the cord/len/cid header fields");
    end
    if (num_in_p < 1) begin : g_bad_num_in
        $error("num_in_p must be at least 1");
    end

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                  state_q, state_d;
    logic [SelW-1:0]         owner_q, owner_d, last_q, last_d, sel, grant;
    logic [len_width_p-1:0]  cnt_q, cnt_d, hdr_len;
    logic [num_in_p-1:0]     empty, full, enq, deq;
    logic [flit_width_p-1:0] head [num_in_p];
    logic                    found, xfer;
    logic [31:0]             scan_idx;

    for (genvar g = 0; g < num_in_p; g++) begin : g_fifo
        logic [flit_width_p-1:0] din;
        logic [flit_width_p-1:0] head_q, tail_q;
        logic [1:0]              count_q;

        assign din                      = links_data_i[g*flit_width_p +: flit_width_p];
        assign empty[g]                 = (count_q == 2'd0);
        assign full[g]                  = (count_q == 2'd2);
        assign links_ready_and_rev_o[g] = ~reset_i & ~full[g];
        assign enq[g]                   = links_v_i[g] & links_ready_and_rev_o[g];
        assign head[g]                  = head_q;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                count_q <= 2'd0;
            end else begin
                case ({enq[g], deq[g]})
                    2'b10: begin
                        if (count_q == 2'd0) head_q <= din;
                        else                 tail_q <= din;
                        count_q <= count_q + 2'd1;
                    end
                    2'b01: begin
                        head_q  <= tail_q;
                        count_q <= count_q - 2'd1;
                    end
                    // Full FIFOs never enqueue, so a simultaneous pair always sees one entry.
                    2'b11: head_q <= din;
                    default: ;
                endcase
            end
        end
    end

    // First non-empty input scanning upward from the one after the last winner.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < num_in_p; k++) begin
            scan_idx = (32'(last_q) + k + 32'd1) % num_in_p;
            if (!found && !empty[SelW'(scan_idx)]) begin
                sel   = SelW'(scan_idx);
                found = 1'b1;
            end
        end
    end

    assign grant                    = (state_q == StBusy) ? owner_q : sel;
    assign concentrated_link_v_o    = ~reset_i & ((state_q == StBusy) ? ~empty[owner_q] : found);
    assign concentrated_link_data_o = head[grant];
    assign hdr_len                  = head[grant][cord_width_p +: len_width_p];
    assign xfer = concentrated_link_v_o & concentrated_link_ready_and_rev_i;

    always_comb begin
        deq = '0;
        if (xfer) deq[grant] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    last_d = sel;
                    if (hdr_len != '0) begin
                        state_d = StBusy;
                        owner_d = sel;
                        cnt_d   = hdr_len;
                    end
                end
            end
            StBusy: begin
                if (xfer) begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    if (cnt_q == len_width_p'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            owner_q <= '0;
            cnt_q   <= '0;
            last_q  <= SelW'(num_in_p - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_concentrator_arbiter.sv
// Directed bench for the concentrator arbiter: per-input source queues feed the DUT and a
// scoreboard queue of expected output flits is checked on every output handshake.
module tb_bsg_wormhole_concentrator_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [2:0]  links_v_i;
    logic [47:0] links_data_i;
    logic [2:0]  ready_o;
    logic        v_o;
    logic [15:0] data_o;
    logic        ds_ready;

    always #5 clk = ~clk;

    bsg_wormhole_concentrator_arbiter #(
        .flit_width_p(16),
        .len_width_p (4),
        .cid_width_p (2),
        .cord_width_p(4),
        .num_in_p    (3)
    ) dut (
        .clk_i                            (clk),
        .reset_i                          (reset_i),
        .links_v_i                        (links_v_i),
        .links_data_i                     (links_data_i),
        .links_ready_and_rev_o            (ready_o),
        .concentrated_link_v_o            (v_o),
        .concentrated_link_data_o         (data_o),
        .concentrated_link_ready_and_rev_i(ds_ready)
    );

    logic [15:0] src_q [3][$];
    logic [15:0] exp_q [$];
    int          out_cyc [$];
    int          want [$];
    logic [2:0]  src_en;
    logic [2:0]  in_acc;
    logic [15:0] exp_flit;
    int          cyc, checks, errors, base;

    // Header: {tag[5:0], cid[1:0], len[3:0], cord[3:0]}
    function automatic logic [15:0] hdr(input logic [5:0] tag, input logic [3:0] len);
        return {tag, 2'b01, len, 4'h5};
    endfunction

    function automatic logic [15:0] body(input logic [5:0] tag, input logic [3:0] n);
        return {tag, 6'h2A, n};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            links_v_i[i] = src_en[i] && (src_q[i].size() > 0);
            links_data_i[i*16 +: 16] = (src_q[i].size() > 0) ? src_q[i][0] : 16'h0;
        end
    endtask

    task automatic send(input int port, input logic [15:0] f);
        src_q[port].push_back(f);
        exp_q.push_back(f);
    endtask

    // One clock cycle: score the output handshake and note input handshakes at the negedge,
    // then retire accepted source flits just after the posedge.
    task automatic step();
        @(negedge clk);
        if (v_o && ds_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_v", v_o, 1'b0);
            end else begin
                exp_flit = exp_q.pop_front();
                chk("out_data", data_o, exp_flit);
                out_cyc.push_back(cyc);
            end
        end
        in_acc = links_v_i & ready_o;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) if (in_acc[i]) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic check_stamps(input string tag);
        chk({tag, "_nout"}, out_cyc.size(), want.size());
        for (int k = 0; k < want.size(); k++)
            if (k < out_cyc.size()) chk({tag, "_cycle"}, out_cyc[k] - base, want[k]);
        out_cyc.delete();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        reset_i   = 1'b1;
        ds_ready  = 1'b1;
        src_en    = 3'b111;
        links_v_i = '0;
        links_data_i = '0;
        drive();

        // Reset state
        step();
        step();
        chk("rst_v", v_o, 1'b0);
        chk("rst_ready", ready_o, 3'b000);
        reset_i = 1'b0;
        #1;
        chk("post_rst_ready", ready_o, 3'b111);
        chk("post_rst_v", v_o, 1'b0);

        // Single packet on input 1, len=2
        base = cyc;
        send(1, hdr(6'h01, 4'd2));
        send(1, body(6'h01, 4'd1));
        send(1, body(6'h01, 4'd2));
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t1_ready1", ready_o[1], 1'b1);
        end
        drain("t1");
        want = '{1, 2, 3};
        check_stamps("t1");

        // Round robin among three header-only packets, input 0 re-presented behind its first
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        base = cyc;
        send(0, hdr(6'h10, 4'd0));
        send(1, hdr(6'h11, 4'd0));
        send(2, hdr(6'h12, 4'd0));
        exp_q.delete();
        exp_q.push_back(hdr(6'h10, 4'd0));
        exp_q.push_back(hdr(6'h11, 4'd0));
        exp_q.push_back(hdr(6'h12, 4'd0));
        send(0, hdr(6'h13, 4'd0));
        drive();
        drain("t2");
        want = '{1, 2, 3, 4};
        check_stamps("t2");

        // No interleave: input 1 header arrives mid-packet and follows with no bubble
        base = cyc;
        send(0, hdr(6'h20, 4'd3));
        send(0, body(6'h20, 4'd1));
        send(0, body(6'h20, 4'd2));
        send(0, body(6'h20, 4'd3));
        drive();
        step();
        step();
        send(1, hdr(6'h21, 4'd0));
        drive();
        drain("t3");
        want = '{1, 2, 3, 4, 5};
        check_stamps("t3");

        // Downstream backpressure 1,0,1,0 during a len=2 packet on input 2
        base = cyc;
        send(2, hdr(6'h30, 4'd2));
        send(2, body(6'h30, 4'd1));
        send(2, body(6'h30, 4'd2));
        drive();
        step();
        ds_ready = 1'b1;
        step();
        ds_ready = 1'b0;
        chk("t4_stall_v", v_o, 1'b1);
        chk("t4_stall_data1", data_o, body(6'h30, 4'd1));
        step();
        ds_ready = 1'b1;
        chk("t4_full_ready2", ready_o[2], 1'b0);
        chk("t4_held_data1", data_o, body(6'h30, 4'd1));
        step();
        ds_ready = 1'b0;
        chk("t4_stall_data2", data_o, body(6'h30, 4'd2));
        chk("t4_ready2_back", ready_o[2], 1'b1);
        step();
        ds_ready = 1'b1;
        drain("t4");
        want = '{1, 3, 5};
        check_stamps("t4");

        // Source stall: input 2 owns the link with its body missing while input 0 waits
        base = cyc;
        send(2, hdr(6'h40, 4'd1));
        drive();
        step();
        src_q[0].push_back(hdr(6'h41, 4'd0));
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_stall_v", v_o, 1'b0);
        end
        send(2, body(6'h40, 4'd1));
        exp_q.delete();
        exp_q.push_back(body(6'h40, 4'd1));
        exp_q.push_back(hdr(6'h41, 4'd0));
        drive();
        drain("t5");
        want = '{1, 7, 8};
        check_stamps("t5");

        // Reset after the first of three body flits
        base = cyc;
        send(0, hdr(6'h50, 4'd3));
        send(0, body(6'h50, 4'd1));
        drive();
        step();
        step();
        step();
        chk("t6_mid_v", v_o, 1'b0);
        reset_i = 1'b1;
        #1;
        chk("t6_rst_v", v_o, 1'b0);
        chk("t6_rst_ready", ready_o, 3'b000);
        step();
        chk("t6_rst_v2", v_o, 1'b0);
        reset_i = 1'b0;
        #1;
        chk("t6_post_ready", ready_o, 3'b111);
        chk("t6_post_cnt", dut.cnt_q, 4'd0);
        want = '{1, 2};
        check_stamps("t6_pre");
        base = cyc;
        send(0, hdr(6'h51, 4'd0));
        drive();
        drain("t6");
        chk("t6_final_cnt", dut.cnt_q, 4'd0);
        want = '{1};
        check_stamps("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
